// File: rtl/dw03_bictr_dcnto_pkg.sv
// rtl/dw03_bictr_dcnto_pkg.sv - shared constants and direction encoding for the
// dynamic terminal-count up/down counter.
package dw03_bictr_dcnto_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

endpackage

// File: rtl/dw03_bictr_dcnto_nxt.sv
// rtl/dw03_bictr_dcnto_nxt.sv - combinational next-count selection (load, up, down, hold).
// DCNTO_AUTORELOAD_EN adds a reload-from-data path on terminal count.
module dw03_bictr_dcnto_nxt
  import dw03_bictr_dcnto_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic [width-1:0] count,
  input  logic [width-1:0] data,
  input  logic             up_dn,
  input  logic             load,
  input  logic             cen,
`ifdef DCNTO_AUTORELOAD_EN
  input  logic             tercnt,
`endif
  output logic [width-1:0] next_count
);

  always_comb begin
    next_count = count;
    if (!load) begin
      next_count = data;
    end
`ifdef DCNTO_AUTORELOAD_EN
    // Reloading on terminal count turns the counter into a data..count_to modulo counter.
    else if (cen && tercnt) begin
      next_count = data;
    end
`endif
    else if (cen && (dir_e'(up_dn) == DIR_UP)) begin
      next_count = count + width'(1);
    end else if (cen) begin
      next_count = count - width'(1);
    end
  end

endmodule

// File: rtl/dw03_bictr_dcnto.sv
// rtl/dw03_bictr_dcnto.sv - loadable up/down counter with a combinational dynamic
// terminal-count flag; DCNTO_AUTORELOAD_EN selects reload-on-terminal-count.
module dw03_bictr_dcnto
  import dw03_bictr_dcnto_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] data,
  input  logic [width-1:0] count_to,
  input  logic             up_dn,
  input  logic             load,
  input  logic             cen,
  output logic [width-1:0] count,
  output logic             tercnt
);

  logic [width-1:0] next_count;

  // Unregistered so the flag follows count_to changes within the same cycle.
  assign tercnt = (count == count_to);

  dw03_bictr_dcnto_nxt #(
    .width(width)
  ) u_nxt (
    .count     (count),
    .data      (data),
    .up_dn     (up_dn),
    .load      (load),
    .cen       (cen),
`ifdef DCNTO_AUTORELOAD_EN
    .tercnt    (tercnt),
`endif
    .next_count(next_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= next_count;
    end
  end

endmodule

// File: tb/tb_dw03_bictr_dcnto.sv
// tb/tb_dw03_bictr_dcnto.sv - scoreboard bench: stimulus pushes expected count/tercnt,
// a monitor pops and compares after each falling and rising edge.
module tb_dw03_bictr_dcnto;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  typedef struct {
    logic [W-1:0] cnt;
    logic         ter;
    string        tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data = '0;
  logic [W-1:0] count_to = '0;
  logic         up_dn = 1'b1;
  logic         load = 1'b1;
  logic         cen = 1'b0;
  logic [W-1:0] count;
  logic         tercnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int unsigned model_cnt = 0;

  dw03_bictr_dcnto #(.width(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .data    (data),
    .count_to(count_to),
    .up_dn   (up_dn),
    .load    (load),
    .cen     (cen),
    .count   (count),
    .tercnt  (tercnt)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge; queue what the DUT must show
  // right now (combinational tercnt) and after the next rising edge.
  task automatic step(input logic rst, input logic ld, input logic [W-1:0] d,
                      input logic [W-1:0] ct, input logic ud, input logic ce,
                      input string tag);
    exp_t e;
    @(negedge clk);
    reset = rst; load = ld; data = d; count_to = ct; up_dn = ud; cen = ce;
    e.cnt = W'(model_cnt); e.ter = (model_cnt == int'(ct)); e.tag = {tag, "_pre"};
    exp_q.push_back(e);
    if (!rst) model_cnt = 0;
    else if (!ld) model_cnt = int'(d);
`ifdef DCNTO_AUTORELOAD_EN
    else if (ce && model_cnt == int'(ct)) model_cnt = int'(d);
`endif
    else if (ce && ud) model_cnt = (model_cnt + 1) % MOD;
    else if (ce) model_cnt = (model_cnt + MOD - 1) % MOD;
    e.cnt = W'(model_cnt); e.ter = (model_cnt == int'(ct)); e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    checks++;
    if (count !== e.cnt) begin
      errors++;
      $display("FAIL %s count got %h want %h", e.tag, count, e.cnt);
    end
    checks++;
    if (tercnt !== e.ter) begin
      errors++;
      $display("FAIL %s tercnt got %b want %b (count_to %h)", e.tag, tercnt, e.ter, count_to);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) compare(exp_q.pop_front());
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) compare(exp_q.pop_front());
    end
  end

  initial begin
    int n;
    step(1'b0, 1'b0, 8'h55, 8'h04, 1'b1, 1'b1, "reset_ct04");
    step(1'b0, 1'b0, 8'h55, 8'h00, 1'b1, 1'b1, "reset_ct00");
    step(1'b1, 1'b0, 8'h0A, 8'h00, 1'b1, 1'b1, "load_0a");
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 8'h77, 8'h00, 1'b1, 1'b0, "hold");
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 8'h00, 8'h10, 1'b1, 1'b1, "up_run");
    step(1'b1, 1'b0, 8'hFE, 8'h00, 1'b0, 1'b0, "load_fe");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, "up_wrap");
    step(1'b1, 1'b0, 8'h01, 8'hFF, 1'b1, 1'b0, "load_01");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, "dn_wrap");
    step(1'b1, 1'b0, 8'h33, 8'h33, 1'b1, 1'b1, "load_beats_cen");
    step(1'b0, 1'b0, 8'h44, 8'h33, 1'b1, 1'b1, "reset_beats_load");
    step(1'b1, 1'b0, 8'h02, 8'h05, 1'b1, 1'b0, "load_02");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'h02, 8'h05, 1'b1, 1'b1, "modulo_run");
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] ct;
      n  = int'($urandom_range(0, 3));
      ct = (n == 0) ? W'(model_cnt) : (n == 1) ? W'(model_cnt + 1) : W'($urandom);
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) != 0), W'($urandom), ct,
           1'($urandom), ($urandom_range(0, 3) != 0), "random");
    end
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
